// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT
    } arb_state_t;

    typedef logic owner_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational winner picker for the memory arbiter.
// MEM_ARB_PRIO_EN: requester 1 has strict priority; otherwise round-robin on last_owner.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  owner_t             last_owner,
    output logic               any,
    output owner_t             winner
);

`ifdef MEM_ARB_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        any    = |req;
        winner = req[1];
    end
`else
    always_comb begin
        any    = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_owner;
            default: winner = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises processor (0) and loader (1) accesses onto a single-ported data memory.
// Build option MEM_ARB_PRIO_EN (in mem_arb_rr) gives requester 1 strict priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] Write,
    input  logic [AW-1:0]      Addr0,
    input  logic [AW-1:0]      Addr1,
    input  logic [DW-1:0]      WData0,
    input  logic [DW-1:0]      WData1,
    output logic [NUM_REQ-1:0] Gnt,
    output logic [NUM_REQ-1:0] RValid,
    output logic [DW-1:0]      RData,
    output logic [AW-1:0]      MemAddr,
    output logic               MemReadEn,
    output logic               MemWriteEn,
    output logic [DW-1:0]      MemWData,
    input  logic [DW-1:0]      MemRData
);

    localparam int CW = 3;

    arb_state_t         state_q, state_d;
    owner_t             last_owner_q, last_owner_d;
    owner_t             owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    logic [AW-1:0]      mem_addr_q, mem_addr_d;
    logic               mem_re_q, mem_re_d;
    logic               mem_we_q, mem_we_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;

    logic               req_any;
    owner_t             winner;

    mem_arb_rr u_rr (
        .req       (Req),
        .last_owner(last_owner_q),
        .any       (req_any),
        .winner    (winner)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        rvalid_d     = '0;
        rdata_d      = rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    // Memory controls are loaded here so they are live for exactly the ISSUE cycle.
                    owner_d        = winner;
                    last_owner_d   = winner;
                    gnt_d[winner]  = 1'b1;
                    mem_addr_d     = winner ? Addr1 : Addr0;
                    mem_wdata_d    = winner ? WData1 : WData0;
                    mem_we_d       = Write[winner];
                    mem_re_d       = ~Write[winner];
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = RDWAIT;
                    cnt_d   = CW'(RD_LATENCY - 1);
                end
            end
            RDWAIT: begin
                if (cnt_q == '0) begin
                    rdata_d           = MemRData;
                    rvalid_d[owner_q] = 1'b1;
                    state_d           = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign Gnt        = gnt_q;
    assign RValid     = rvalid_q;
    assign RData      = rdata_q;
    assign MemAddr    = mem_addr_q;
    assign MemReadEn  = mem_re_q;
    assign MemWriteEn = mem_we_q;
    assign MemWData   = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LATENCY 1 and 3), each with its own memory model.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_i [2];
    logic [1:0]  req_i [2];
    logic [1:0]  wr_i  [2];
    logic [15:0] a0_i  [2];
    logic [15:0] a1_i  [2];
    logic [31:0] wd0_i [2];
    logic [31:0] wd1_i [2];
    logic [1:0]  gnt_o [2];
    logic [1:0]  rv_o  [2];
    logic [31:0] rd_o  [2];
    logic [15:0] maddr [2];
    logic        mre   [2];
    logic        mwe   [2];
    logic [31:0] mwd   [2];
    logic [31:0] mrd   [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t mon_e;

    logic [31:0] ref_mem [2][256];
    int          ren_cnt [2];
    int          wen_cnt [2];
    int          rv_cnt  [2];
    int          gnt_cnt [2];
    int          last_rv_cyc [2];
    int          prev_rv_cyc [2];
    logic [15:0] last_ren_addr [2];
    logic [15:0] last_wen_addr [2];
    logic [31:0] last_wdata [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem  [256];
        logic [31:0] pipe [L];

        mem_arbiter #(.AW(16), .DW(32), .RD_LATENCY(L)) u_dut (
            .Clock     (clk),
            .Reset     (rst_i[g]),
            .Req       (req_i[g]),
            .Write     (wr_i[g]),
            .Addr0     (a0_i[g]),
            .Addr1     (a1_i[g]),
            .WData0    (wd0_i[g]),
            .WData1    (wd1_i[g]),
            .Gnt       (gnt_o[g]),
            .RValid    (rv_o[g]),
            .RData     (rd_o[g]),
            .MemAddr   (maddr[g]),
            .MemReadEn (mre[g]),
            .MemWriteEn(mwe[g]),
            .MemWData  (mwd[g]),
            .MemRData  (mrd[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 32'h0;
            mem[8'h10] = 32'hDEADBEEF;
            mem[8'h00] = 32'h11111111;
            mem[8'h04] = 32'h22222222;
        end

        // Read data appears L edges after the ReadEn edge; filler exposes wrong sampling time.
        always @(posedge clk) begin
            if (mwe[g]) mem[maddr[g][7:0]] <= mwd[g];
            pipe[0] <= mre[g] ? mem[maddr[g][7:0]] : 32'hBADBAD00;
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mrd[g] = pipe[L-1];
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rst_i[d]) begin
                total++;
                if ((mre[d] & mwe[d]) !== 1'b0) begin
                    bad++;
                    $display("FAIL enable_overlap dut%0d: re=%b we=%b, required not both high", d, mre[d], mwe[d]);
                end
                total++;
                if (!$onehot0(gnt_o[d])) begin
                    bad++;
                    $display("FAIL gnt_onehot dut%0d: got %b, required onehot0", d, gnt_o[d]);
                end
                total++;
                if (!$onehot0(rv_o[d])) begin
                    bad++;
                    $display("FAIL rvalid_onehot dut%0d: got %b, required onehot0", d, rv_o[d]);
                end
                if (mre[d]) begin ren_cnt[d]++; last_ren_addr[d] = maddr[d]; end
                if (mwe[d]) begin wen_cnt[d]++; last_wen_addr[d] = maddr[d]; last_wdata[d] = mwd[d]; end
                if (gnt_o[d] != 2'b00) gnt_cnt[d]++;
                if (rv_o[d] != 2'b00) begin
                    rv_cnt[d]++;
                    prev_rv_cyc[d] = last_rv_cyc[d];
                    last_rv_cyc[d] = cyc;
                    total++;
                    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                        bad++;
                        $display("FAIL unexpected_rvalid dut%0d: got %b, required none", d, rv_o[d]);
                    end else begin
                        if (d == 0) mon_e = sb0.pop_front();
                        else        mon_e = sb1.pop_front();
                        if (rv_o[d] !== (2'b01 << mon_e.owner) || rd_o[d] !== mon_e.data) begin
                            bad++;
                            $display("FAIL read_result dut%0d: got rv=%b data=%h, required rv=%b data=%h",
                                     d, rv_o[d], rd_o[d], 2'b01 << mon_e.owner, mon_e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int d, input logic owner, input logic [31:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic do_reset(input int d);
        rst_i[d] = 1'b1;
        req_i[d] = 2'b00;
        if (d == 0) sb0.delete();
        else        sb1.delete();
        tick(2);
        rst_i[d] = 1'b0;
        tick(1);
    endtask

    task automatic wait_any(input int d, output logic [1:0] g);
        g = 2'b00;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt_o[d] != 2'b00) begin
                g = gnt_o[d];
                break;
            end
        end
        if (g == 2'b00) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout dut%0d: got no grant, required a grant within 40 cycles", d);
        end
    endtask

    task automatic check_all_zero(input int d, input string tag);
        logic [85:0] v;
        v = {gnt_o[d], rv_o[d], rd_o[d], maddr[d], mre[d], mwe[d], mwd[d]};
        total++;
        if (v !== '0) begin
            bad++;
            $display("FAIL %s dut%0d: outputs got %h, required 0", tag, d, v);
        end
    endtask

    task automatic test_reset();
        rst_i[0] = 1'b1;
        rst_i[1] = 1'b1;
        tick(2);
        check_all_zero(0, "reset_outputs");
        check_all_zero(1, "reset_outputs");
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;
        tick(2);
        check_all_zero(0, "idle_outputs");
        check_all_zero(1, "idle_outputs");
    endtask

    task automatic test_single_read(input int d);
        int L = (d == 0) ? 1 : 3;
        int s_ren = ren_cnt[d];
        int gc = 0, gcyc = 0, rcyc = 0;
        wr_i[d]  = 2'b00;
        a0_i[d]  = 16'h0010;
        req_i[d] = 2'b01;
        push_exp(d, 1'b0, 32'hDEADBEEF);
        for (int n = 1; n <= L + 6; n++) begin
            @(negedge clk);
            if (gnt_o[d] != 2'b00) begin
                gc++;
                gcyc = n;
                total++;
                if (gnt_o[d] !== 2'b01) begin
                    bad++;
                    $display("FAIL read_gnt dut%0d: got %b, required 01", d, gnt_o[d]);
                end
                req_i[d] = 2'b00;
            end
            if (rv_o[d] != 2'b00 && rcyc == 0) rcyc = n;
        end
        total++;
        if (gc != 1 || gcyc != 1) begin
            bad++;
            $display("FAIL read_gnt_count dut%0d: got %0d grants at cycle %0d, required 1 at cycle 1", d, gc, gcyc);
        end
        total++;
        if (rcyc != L + 2) begin
            bad++;
            $display("FAIL read_latency dut%0d: got %0d, required %0d", d, rcyc, L + 2);
        end
        total++;
        if (ren_cnt[d] - s_ren != 1 || last_ren_addr[d] !== 16'h0010) begin
            bad++;
            $display("FAIL read_mem_access dut%0d: got %0d reads at %h, required 1 at 0010",
                     d, ren_cnt[d] - s_ren, last_ren_addr[d]);
        end
        total++;
        if (rd_o[d] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rdata_hold dut%0d: got %h, required deadbeef", d, rd_o[d]);
        end
    endtask

    task automatic test_write_then_read();
        logic [1:0] g;
        int s_w  = wen_cnt[0];
        int s_rv = rv_cnt[0];
        wr_i[0]  = 2'b10;
        a1_i[0]  = 16'h0004;
        wd1_i[0] = 32'h3C011234;
        req_i[0] = 2'b10;
        ref_mem[0][8'h04] = 32'h3C011234;
        wait_any(0, g);
        total++;
        if (g !== 2'b10) begin
            bad++;
            $display("FAIL write_gnt: got %b, required 10", g);
        end
        req_i[0] = 2'b00;
        tick(6);
        total++;
        if (wen_cnt[0] - s_w != 1 || last_wen_addr[0] !== 16'h0004 || last_wdata[0] !== 32'h3C011234) begin
            bad++;
            $display("FAIL write_mem_access: got %0d writes %h<=%h, required 1 write 0004<=3c011234",
                     wen_cnt[0] - s_w, last_wen_addr[0], last_wdata[0]);
        end
        total++;
        if (rv_cnt[0] != s_rv) begin
            bad++;
            $display("FAIL write_no_rvalid: got %0d pulses, required 0", rv_cnt[0] - s_rv);
        end
        wr_i[0]  = 2'b00;
        a0_i[0]  = 16'h0004;
        req_i[0] = 2'b01;
        push_exp(0, 1'b0, ref_mem[0][8'h04]);
        wait_any(0, g);
        req_i[0] = 2'b00;
        tick(6);
        total++;
        if (rv_cnt[0] - s_rv != 1 || rd_o[0] !== 32'h3C011234) begin
            bad++;
            $display("FAIL readback: got %0d pulses data=%h, required 1 pulse data=3c011234",
                     rv_cnt[0] - s_rv, rd_o[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [3:0] exp_seq;
        int s_g;
`ifdef MEM_ARB_PRIO_EN
        exp_seq = 4'b1111;
`else
        exp_seq = 4'b1010;
`endif
        do_reset(0);
        s_g = gnt_cnt[0];
        wr_i[0]  = 2'b11;
        a0_i[0]  = 16'h0020;
        wd0_i[0] = 32'hA0A0A0A0;
        a1_i[0]  = 16'h0024;
        wd1_i[0] = 32'hB1B1B1B1;
        req_i[0] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_any(0, g);
            total++;
            if (g !== (2'b01 << exp_seq[k])) begin
                bad++;
                $display("FAIL arb_order grant%0d: got %b, required %b", k, g, 2'b01 << exp_seq[k]);
            end
        end
        req_i[0] = 2'b00;
        tick(8);
        total++;
        if (gnt_cnt[0] - s_g != 4) begin
            bad++;
            $display("FAIL arb_grant_count: got %0d, required 4", gnt_cnt[0] - s_g);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g;
        int s_rv  = rv_cnt[1];
        int s_ren = ren_cnt[1];
        push_exp(1, 1'b0, ref_mem[1][8'h00]);
        push_exp(1, 1'b0, ref_mem[1][8'h04]);
        wr_i[1]  = 2'b00;
        a0_i[1]  = 16'h0000;
        req_i[1] = 2'b01;
        wait_any(1, g);
        a0_i[1]  = 16'h0004;
        wait_any(1, g);
        req_i[1] = 2'b00;
        tick(12);
        total++;
        if (rv_cnt[1] - s_rv != 2 || ren_cnt[1] - s_ren != 2) begin
            bad++;
            $display("FAIL b2b_count: got %0d pulses %0d reads, required 2 and 2",
                     rv_cnt[1] - s_rv, ren_cnt[1] - s_ren);
        end
        total++;
        if (last_rv_cyc[1] - prev_rv_cyc[1] != 5) begin
            bad++;
            $display("FAIL b2b_spacing: got %0d, required 5", last_rv_cyc[1] - prev_rv_cyc[1]);
        end
        total++;
        if (rd_o[1] !== 32'h22222222) begin
            bad++;
            $display("FAIL b2b_last_data: got %h, required 22222222", rd_o[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        int s_rv;
        wr_i[1]  = 2'b00;
        a0_i[1]  = 16'h0010;
        req_i[1] = 2'b01;
        wait_any(1, g);
        req_i[1] = 2'b00;
        tick(2);
        #1;
        rst_i[1] = 1'b1;
        s_rv = rv_cnt[1];
        #1;
        check_all_zero(1, "mid_reset_outputs");
        tick(2);
        rst_i[1] = 1'b0;
        tick(6);
        total++;
        if (rv_cnt[1] != s_rv) begin
            bad++;
            $display("FAIL aborted_rvalid: got %0d pulses, required 0", rv_cnt[1] - s_rv);
        end
`ifdef MEM_ARB_PRIO_EN
        push_exp(1, 1'b1, ref_mem[1][8'h00]);
        push_exp(1, 1'b0, 32'hDEADBEEF);
`else
        push_exp(1, 1'b0, 32'hDEADBEEF);
        push_exp(1, 1'b1, ref_mem[1][8'h00]);
`endif
        s_rv = rv_cnt[1];
        a0_i[1]  = 16'h0010;
        a1_i[1]  = 16'h0000;
        wr_i[1]  = 2'b00;
        req_i[1] = 2'b11;
        wait_any(1, g);
        total++;
`ifdef MEM_ARB_PRIO_EN
        if (g !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_tie: got %b, required 10", g);
        end
`else
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL post_reset_tie: got %b, required 01", g);
        end
`endif
        req_i[1] = req_i[1] & ~g;
        wait_any(1, g);
        req_i[1] = 2'b00;
        tick(10);
        total++;
        if (rv_cnt[1] - s_rv != 2) begin
            bad++;
            $display("FAIL post_reset_reads: got %0d pulses, required 2", rv_cnt[1] - s_rv);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1;
            req_i[d] = 2'b00;
            wr_i[d]  = 2'b00;
            a0_i[d]  = '0;
            a1_i[d]  = '0;
            wd0_i[d] = '0;
            wd1_i[d] = '0;
            ren_cnt[d] = 0; wen_cnt[d] = 0; rv_cnt[d] = 0; gnt_cnt[d] = 0;
            last_rv_cyc[d] = 0; prev_rv_cyc[d] = 0;
            last_ren_addr[d] = '0; last_wen_addr[d] = '0; last_wdata[d] = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = 32'h0;
            ref_mem[d][8'h10] = 32'hDEADBEEF;
            ref_mem[d][8'h00] = 32'h11111111;
            ref_mem[d][8'h04] = 32'h22222222;
        end
        test_reset();
        test_single_read(0);
        test_single_read(1);
        test_write_then_read();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
